// File: rtl/mem_if_pkg.sv
// Shared definitions for the MEM-stage data-memory interface.
// Holds the word width, the default memory map (base address and depth),
// the responder state encoding, and the address-error check.
package mem_if_pkg;

  localparam int          WORD_W            = 32;
  localparam int          DEFAULT_DEPTH     = 64;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Out-of-range (below base or past the last word) or not word aligned.
  // The offset wraps in 32-bit unsigned arithmetic, so the explicit
  // below-base test is needed alongside the index bound.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    return (addr < base) || ({2'b00, off[31:2]} >= depth) || (off[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dm_word_array.sv
// Word-organised data array of the data-memory responder.
// Ports:
//   clk   - system clock, rising edge
//   we    - write enable, write happens on the rising edge
//   idx   - word index shared by the read and write ports
//   wdata - write data
//   rdata - asynchronous read data of word idx
// The array has no reset; its contents survive a responder reset.
module dm_word_array
  import mem_if_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_r [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[idx] <= wdata;
    end
  end

  assign rdata = mem_r[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side end of the MEM-stage data-memory interface.
// Accepts one load/store at a time and answers after WAIT_CYCLES cycles.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   req_valid  - request present; req_write 1 = store, 0 = load
//   req_addr   - byte address; req_wdata - store data
//   req_ready  - responder can accept a request (registered)
//   rsp_valid  - one-cycle completion pulse (registered)
//   rsp_rdata  - load data, 0 for stores and errors (registered)
//   rsp_err    - out-of-range or misaligned address (registered)
//   busy       - transaction outstanding, used as a pipeline stall
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int          DEPTH       = DEFAULT_DEPTH,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e            state_r;
  state_e            next_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_next_s;
  logic              write_r;
  logic [WORD_W-1:0] addr_r;
  logic [WORD_W-1:0] wdata_r;

  logic              accept_s;
  logic              eff_write_s;
  logic [WORD_W-1:0] eff_addr_s;
  logic [WORD_W-1:0] off_s;
  logic              err_s;
  logic [IDX_W-1:0]  idx_s;
  logic              we_s;
  logic [WORD_W-1:0] arr_rdata_s;
  logic [WORD_W-1:0] rdata_next_s;

  // Address path: the live request while accepting (needed when the
  // response follows acceptance immediately), otherwise the captured one.
  always_comb begin
    accept_s = (state_r == IDLE) && req_valid;
    if (accept_s) begin
      eff_write_s = req_write;
      eff_addr_s  = req_addr;
    end else begin
      eff_write_s = write_r;
      eff_addr_s  = addr_r;
    end
    off_s = eff_addr_s - BASE_ADDR;
    err_s = addr_err(eff_addr_s, BASE_ADDR, 32'(DEPTH));
    idx_s = IDX_W'(off_s >> 2);
    // The store commits at the end of the response cycle.
    we_s  = (state_r == DONE) && write_r && !err_s;
  end

  dm_word_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (we_s),
    .idx   (idx_s),
    .wdata (wdata_r),
    .rdata (arr_rdata_s)
  );

  // Next-state and wait counter. The counter reaches zero on the edge
  // that enters DONE, so WAIT lasts WAIT_CYCLES-1 cycles.
  always_comb begin
    next_s     = state_r;
    cnt_next_s = cnt_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          cnt_next_s = CNT_LOAD;
          if (CNT_LOAD == 4'd0) begin
            next_s = DONE;
          end else begin
            next_s = WAIT;
          end
        end else begin
          next_s = IDLE;
        end
      end
      WAIT: begin
        cnt_next_s = cnt_r - 4'd1;
        if (cnt_next_s == 4'd0) begin
          next_s = DONE;
        end else begin
          next_s = WAIT;
        end
      end
      DONE: begin
        cnt_next_s = 4'd0;
        next_s     = IDLE;
      end
      default: begin
        cnt_next_s = 4'd0;
        next_s     = IDLE;
      end
    endcase

    if ((next_s == DONE) && !eff_write_s && !err_s) begin
      rdata_next_s = arr_rdata_s;
    end else begin
      rdata_next_s = '0;
    end
  end

  // State, counter and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_r   <= next_s;
      cnt_r     <= cnt_next_s;
      req_ready <= (next_s == IDLE);
      busy      <= (next_s != IDLE);
      rsp_valid <= (next_s == DONE);
      rsp_rdata <= rdata_next_s;
      rsp_err   <= (next_s == DONE) && err_s;
    end
  end

  // Request capture; inputs are don't-care after acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_r <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (accept_s) begin
      write_r <= req_write;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side end of the MEM-stage data-memory interface: accepts one load/store request at a time from the pipeline's MEM stage and answers after a fixed, configurable number of wait states.
- Holds the word-organised data array, translates byte addresses from the ALU result into word indices, and flags out-of-range accesses.
- Drives `busy` so the hazard/freeze logic can stall the pipeline while a transaction is outstanding.

Parameters:
- DEPTH, 64, number of 32-bit words in the array.
- BASE_ADDR, 1024, byte address that maps to word 0.
- WAIT_CYCLES, 4, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address (ALU result).
- req_wdata  input  32  store data (Rm value).
- req_ready  output  1  responder can accept a request.
- rsp_valid  output  1  one-cycle pulse: transaction complete.
- rsp_rdata  output  32  load data; valid only while rsp_valid=1.
- rsp_err  output  1  out-of-range or misaligned address; valid only while rsp_valid=1.
- busy  output  1  transaction outstanding (stall request).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Array contents are not cleared.
- A request is accepted on a rising edge with req_valid=1 and req_ready=1. On acceptance, write, addr and wdata are captured into internal registers. Inputs are don't-care after acceptance.
- Address translation:
  - off = req_addr - BASE_ADDR, computed in 32-bit unsigned arithmetic.
  - index = off[31:2].
  - err = (req_addr < BASE_ADDR) | (index >= DEPTH) | (off[1:0] != 0).
- FSM states:
  - IDLE: req_ready=1, busy=0. On acceptance, load counter = WAIT_CYCLES-1 and go to WAIT.
  - WAIT: req_ready=0, busy=1. Counter decrements each cycle; go to DONE when counter==0 at the clock edge.
  - DONE: req_ready=0, busy=1, rsp_valid=1.
    - Load: rsp_rdata = array[index], or 0 if err.
    - Store: the write commits at the end of this cycle only if err=0. rsp_rdata=0.
    - rsp_err=err. Next state is IDLE unconditionally.
- Latency: request accepted at edge N, so rsp_valid is high in cycle N+WAIT_CYCLES. Back-to-back throughput is one transaction per WAIT_CYCLES+1 cycles.
- Outputs are registered. rsp_rdata and rsp_err return to 0 in the cycle after DONE.
- req_valid while not ready is ignored, not queued. The requester must hold it until it sees req_ready=1.
- A load to an address stored by the immediately preceding transaction returns the new data, because the store commits before the next acceptance.
- Reset mid-transaction: the transaction is abandoned, no write occurs, and the block is in IDLE on the first edge after rst releases.
- Errored stores leave the array unchanged. An errored load returns rdata=0 with rsp_err=1.

Decomposition:
- Shared package `mem_if_pkg`:
  - state enum {IDLE, WAIT, DONE}.
  - WORD_W=32.
  - Default BASE_ADDR and DEPTH constants, shared with the MEM stage.
- One sub-module `dm_word_array`:
  - Synchronous write port (we, idx, wdata).
  - Asynchronous read port (idx → rdata).
  - No reset.
  - Instantiated once by the responder.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then release → req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0 for 10 idle cycles.
- Store then load: store 0xDEADBEEF to 1028, then load 1028 with WAIT_CYCLES=4 → store response 4 cycles after acceptance with rsp_err=0; load response 4 cycles after its acceptance with rsp_rdata=0xDEADBEEF.
- Boundaries:
  - Store to 1024+4*63=1276, then load it back → data matches, rsp_err=0.
  - Load 1280 → rsp_err=1, rdata=0.
  - Load 1020 → rsp_err=1, rdata=0.
  - Store 0x5 to 1026 (misaligned) → rsp_err=1; a subsequent load of 1024 returns its prior value.
- Handshake: hold req_valid=1 continuously with alternating requests → acceptances every 5 cycles (WAIT_CYCLES=4); busy high exactly 4 of every 5 cycles; no request dropped or duplicated.
- Reset mid-operation:
  - Store 0x1234 to 1032 and assert rst=0 two cycles after acceptance.
  - After release, load 1032 → value unchanged from before the store.
  - rsp_valid never pulsed for the aborted store.
- WAIT_CYCLES=1: rsp_valid is high in the cycle right after acceptance; back-to-back transactions accepted every 2 cycles.
